// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing with programmable sync polarity,
// pipelined sync/de outputs and x1/x2/x4 replicated frame-buffer addressing.
module video_timing_gen #(
    parameter int H_DISPLAY  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_DISPLAY  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0,
    parameter int PIPE_DELAY = 2,
    parameter int CNT_W      = 11,
    parameter int ADDR_W     = 19
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pix_ce,
    input  logic [1:0]        h_scale,
    input  logic [1:0]        v_scale,
    output logic [CNT_W-1:0]  hpos,
    output logic [CNT_W-1:0]  vpos,
    output logic [ADDR_W-1:0] display_addr,
    output logic              hsync,
    output logic              vsync,
    output logic              display_on,
    output logic              frame_start,
    output logic              line_start
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_DE_END = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] V_DE_END = CNT_W'(V_DISPLAY);
    localparam logic [CNT_W-1:0] H_SY_BEG = CNT_W'(H_DISPLAY + H_FRONT);
    localparam logic [CNT_W-1:0] H_SY_END = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] V_SY_BEG = CNT_W'(V_DISPLAY + V_FRONT);
    localparam logic [CNT_W-1:0] V_SY_END = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic [ADDR_W-1:0] H_DISP_A = ADDR_W'(H_DISPLAY);
    localparam logic H_ACT = H_SYNC_POL[0];
    localparam logic V_ACT = V_SYNC_POL[0];

    logic [CNT_W-1:0]      r_hpos, r_vpos;
    logic [ADDR_W-1:0]     r_addr, r_line_base;
    logic [1:0]            r_hscale, r_vscale, r_sub_px, r_sub_ln;
    logic [PIPE_DELAY-1:0] r_de_pipe, r_hs_pipe, r_vs_pipe;
    logic                  r_frame_start, r_line_start;

    logic                  w_h_wrap, w_v_wrap, w_frame, w_de_nx;
    logic                  w_de_raw, w_hs_raw, w_vs_raw;
    logic [CNT_W-1:0]      w_hpos_nx, w_vpos_nx;
    logic [1:0]            w_hscale_nx, w_vscale_nx, w_px_max, w_ln_max;
    logic [1:0]            w_sub_px_nx, w_sub_ln_nx;
    logic [ADDR_W-1:0]     w_stride, w_base_nx, w_addr_nx;

    assign w_h_wrap    = r_hpos == H_LAST;
    assign w_v_wrap    = r_vpos == V_LAST;
    assign w_frame     = w_h_wrap && w_v_wrap;
    assign w_hpos_nx   = w_h_wrap ? '0 : r_hpos + 1'b1;
    assign w_vpos_nx   = !w_h_wrap ? r_vpos : (w_v_wrap ? '0 : r_vpos + 1'b1);
    assign w_de_nx     = w_hpos_nx < H_DE_END && w_vpos_nx < V_DE_END;
    assign w_de_raw    = r_hpos < H_DE_END && r_vpos < V_DE_END;
    assign w_hs_raw    = r_hpos >= H_SY_BEG && r_hpos < H_SY_END;
    assign w_vs_raw    = r_vpos >= V_SY_BEG && r_vpos < V_SY_END;
    assign w_hscale_nx = h_scale == 2'd0 ? 2'd0 : (h_scale == 2'd1 ? 2'd1 : 2'd2);
    assign w_vscale_nx = v_scale == 2'd0 ? 2'd0 : (v_scale == 2'd1 ? 2'd1 : 2'd2);
    assign w_px_max    = r_hscale == 2'd0 ? 2'd0 : (r_hscale == 2'd1 ? 2'd1 : 2'd3);
    assign w_ln_max    = r_vscale == 2'd0 ? 2'd0 : (r_vscale == 2'd1 ? 2'd1 : 2'd3);
    assign w_stride    = H_DISP_A >> r_hscale;

    // Address tracks the position the counters move to, so it lands in the same edge.
    always_comb begin
        w_base_nx   = r_line_base;
        w_addr_nx   = r_addr;
        w_sub_px_nx = r_sub_px;
        w_sub_ln_nx = r_sub_ln;
        if (w_frame) begin
            w_base_nx   = '0;
            w_addr_nx   = '0;
            w_sub_px_nx = '0;
            w_sub_ln_nx = '0;
        end else if (w_h_wrap) begin
            if (w_de_nx) begin
                w_sub_ln_nx = r_sub_ln == w_ln_max ? 2'd0 : r_sub_ln + 2'd1;
                w_base_nx   = r_sub_ln == w_ln_max ? r_line_base + w_stride : r_line_base;
                w_addr_nx   = w_base_nx;
                w_sub_px_nx = '0;
            end
        end else if (w_de_nx) begin
            w_sub_px_nx = r_sub_px == w_px_max ? 2'd0 : r_sub_px + 2'd1;
            w_addr_nx   = r_sub_px == w_px_max ? r_addr + 1'b1 : r_addr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hpos        <= H_LAST;
            r_vpos        <= V_LAST;
            r_addr        <= '0;
            r_line_base   <= '0;
            r_sub_px      <= '0;
            r_sub_ln      <= '0;
            r_hscale      <= '0;
            r_vscale      <= '0;
            r_de_pipe     <= '0;
            r_hs_pipe     <= '0;
            r_vs_pipe     <= '0;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
        end else begin
            r_frame_start <= pix_ce && w_frame;
            r_line_start  <= pix_ce && w_h_wrap;
            if (pix_ce) begin
                r_hpos      <= w_hpos_nx;
                r_vpos      <= w_vpos_nx;
                r_addr      <= w_addr_nx;
                r_line_base <= w_base_nx;
                r_sub_px    <= w_sub_px_nx;
                r_sub_ln    <= w_sub_ln_nx;
                r_de_pipe   <= (r_de_pipe << 1) | PIPE_DELAY'(w_de_raw);
                r_hs_pipe   <= (r_hs_pipe << 1) | PIPE_DELAY'(w_hs_raw);
                r_vs_pipe   <= (r_vs_pipe << 1) | PIPE_DELAY'(w_vs_raw);
                if (w_frame) begin
                    r_hscale <= w_hscale_nx;
                    r_vscale <= w_vscale_nx;
                end
            end
        end
    end

    assign hpos         = r_hpos;
    assign vpos         = r_vpos;
    assign display_addr = r_addr;
    assign display_on   = r_de_pipe[PIPE_DELAY-1];
    assign hsync        = r_hs_pipe[PIPE_DELAY-1] ? H_ACT : ~H_ACT;
    assign vsync        = r_vs_pipe[PIPE_DELAY-1] ? V_ACT : ~V_ACT;
    assign frame_start  = r_frame_start;
    assign line_start   = r_line_start;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: three configurations driven with random pixel enables and
// scales, scored against an arithmetic raster model through an expectation queue.
module tb_video_timing_gen;
    localparam int HD[3]  = '{640, 16, 12};
    localparam int HF[3]  = '{16, 2, 1};
    localparam int HSY[3] = '{96, 3, 2};
    localparam int HB[3]  = '{48, 3, 2};
    localparam int VD[3]  = '{480, 8, 6};
    localparam int VF[3]  = '{10, 1, 2};
    localparam int VSY[3] = '{2, 2, 1};
    localparam int VB[3]  = '{33, 2, 1};
    localparam int POL[3] = '{0, 0, 1};
    localparam int PD[3]  = '{2, 4, 1};
    localparam int AW[3]  = '{19, 19, 5};

    typedef struct {
        logic [31:0] hpos, vpos, addr;
        logic        hs, vs, de, fs, ls;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ce[3];
    logic [1:0] hsc[3], vsc[3];

    logic [10:0] hpos0, vpos0;
    logic [18:0] addr0;
    logic [5:0]  hpos1, vpos1;
    logic [18:0] addr1;
    logic [4:0]  hpos2, vpos2;
    logic [4:0]  addr2;
    logic hs0, vs0, de0, fs0, ls0;
    logic hs1, vs1, de1, fs1, ls1;
    logic hs2, vs2, de2, fs2, ls2;

    exp_t q[$];
    int n[3], shs[3], svs[3], laddr[3];
    int vectors = 0, miscompares = 0, cyc = 0;
    bit started = 0;

    always #5 clk = ~clk;

    video_timing_gen dut0 (
        .clk(clk), .reset_n(reset_n), .pix_ce(ce[0]), .h_scale(hsc[0]), .v_scale(vsc[0]),
        .hpos(hpos0), .vpos(vpos0), .display_addr(addr0), .hsync(hs0), .vsync(vs0),
        .display_on(de0), .frame_start(fs0), .line_start(ls0)
    );

    video_timing_gen #(
        .H_DISPLAY(HD[1]), .H_FRONT(HF[1]), .H_SYNC(HSY[1]), .H_BACK(HB[1]),
        .V_DISPLAY(VD[1]), .V_FRONT(VF[1]), .V_SYNC(VSY[1]), .V_BACK(VB[1]),
        .H_SYNC_POL(POL[1]), .V_SYNC_POL(POL[1]), .PIPE_DELAY(PD[1]),
        .CNT_W(6), .ADDR_W(AW[1])
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .pix_ce(ce[1]), .h_scale(hsc[1]), .v_scale(vsc[1]),
        .hpos(hpos1), .vpos(vpos1), .display_addr(addr1), .hsync(hs1), .vsync(vs1),
        .display_on(de1), .frame_start(fs1), .line_start(ls1)
    );

    video_timing_gen #(
        .H_DISPLAY(HD[2]), .H_FRONT(HF[2]), .H_SYNC(HSY[2]), .H_BACK(HB[2]),
        .V_DISPLAY(VD[2]), .V_FRONT(VF[2]), .V_SYNC(VSY[2]), .V_BACK(VB[2]),
        .H_SYNC_POL(POL[2]), .V_SYNC_POL(POL[2]), .PIPE_DELAY(PD[2]),
        .CNT_W(5), .ADDR_W(AW[2])
    ) dut2 (
        .clk(clk), .reset_n(reset_n), .pix_ce(ce[2]), .h_scale(hsc[2]), .v_scale(vsc[2]),
        .hpos(hpos2), .vpos(vpos2), .display_addr(addr2), .hsync(hs2), .vsync(vs2),
        .display_on(de2), .frame_start(fs2), .line_start(ls2)
    );

    function automatic int dec(input logic [1:0] s);
        return s == 2'd0 ? 0 : (s == 2'd1 ? 1 : 2);
    endfunction

    function automatic exp_t rst_exp(input int k);
        exp_t e;
        e.hpos = 32'(HD[k] + HF[k] + HSY[k] + HB[k] - 1);
        e.vpos = 32'(VD[k] + VF[k] + VSY[k] + VB[k] - 1);
        e.addr = 32'd0;
        e.de = 1'b0;
        e.hs = ~POL[k][0];
        e.vs = ~POL[k][0];
        e.fs = 1'b0;
        e.ls = 1'b0;
        return e;
    endfunction

    // Reference: position is just the tick count folded onto the raster; the delayed
    // outputs are the raster decode of the position PIPE_DELAY ticks earlier.
    task automatic model(input int k, input bit held, input bit pulse);
        exp_t e;
        int ht, vt, idx, h, v, j;
        bit in_hs, in_vs, in_de;
        ht = HD[k] + HF[k] + HSY[k] + HB[k];
        vt = VD[k] + VF[k] + VSY[k] + VB[k];
        e.fs = 1'b0;
        e.ls = 1'b0;
        if (held || pulse) begin
            n[k] = 0; shs[k] = 0; svs[k] = 0; laddr[k] = 0;
        end
        if (!held && ce[k]) begin
            n[k]++;
            idx = n[k] - 1;
            h = idx % ht;
            v = (idx / ht) % vt;
            e.ls = h == 0;
            e.fs = h == 0 && v == 0;
            if (e.fs) begin
                shs[k] = dec(hsc[k]);
                svs[k] = dec(vsc[k]);
            end
            if (h < HD[k] && v < VD[k])
                laddr[k] = ((v >> svs[k]) * (HD[k] >> shs[k]) + (h >> shs[k])) % (1 << AW[k]);
        end
        e.hpos = 32'(n[k] == 0 ? ht - 1 : (n[k] - 1) % ht);
        e.vpos = 32'(n[k] == 0 ? vt - 1 : ((n[k] - 1) / ht) % vt);
        e.addr = 32'(laddr[k]);
        j = n[k] - 1 - PD[k];
        in_de = 0; in_hs = 0; in_vs = 0;
        if (j >= 0) begin
            h = j % ht;
            v = (j / ht) % vt;
            in_de = h < HD[k] && v < VD[k];
            in_hs = h >= HD[k] + HF[k] && h < HD[k] + HF[k] + HSY[k];
            in_vs = v >= VD[k] + VF[k] && v < VD[k] + VF[k] + VSY[k];
        end
        e.de = in_de;
        e.hs = in_hs ? POL[k][0] : ~POL[k][0];
        e.vs = in_vs ? POL[k][0] : ~POL[k][0];
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s inst%0d t=%0t got %0d expected %0d", nm, k, $time, got, exp);
        end
    endtask

    task automatic check_inst(input int k, input exp_t e);
        logic [31:0] gh, gv, ga;
        logic ghs, gvs, gde, gfs, gls;
        case (k)
            0: begin gh = 32'(hpos0); gv = 32'(vpos0); ga = 32'(addr0);
                     ghs = hs0; gvs = vs0; gde = de0; gfs = fs0; gls = ls0; end
            1: begin gh = 32'(hpos1); gv = 32'(vpos1); ga = 32'(addr1);
                     ghs = hs1; gvs = vs1; gde = de1; gfs = fs1; gls = ls1; end
            default: begin gh = 32'(hpos2); gv = 32'(vpos2); ga = 32'(addr2);
                     ghs = hs2; gvs = vs2; gde = de2; gfs = fs2; gls = ls2; end
        endcase
        chk("hpos", k, gh, e.hpos);
        chk("vpos", k, gv, e.vpos);
        chk("display_addr", k, ga, e.addr);
        chk("hsync", k, 32'(ghs), 32'(e.hs));
        chk("vsync", k, 32'(gvs), 32'(e.vs));
        chk("display_on", k, 32'(gde), 32'(e.de));
        chk("frame_start", k, 32'(gfs), 32'(e.fs));
        chk("line_start", k, 32'(gls), 32'(e.ls));
    endtask

    task automatic step(input bit rel, input bit pulse, input int mode);
        @(negedge clk);
        if (rel) reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (mode == 0) begin
                ce[k] = 1'b1;
                hsc[k] = k == 0 ? 2'd1 : 2'($urandom_range(0, 3));
                vsc[k] = k == 0 ? 2'd1 : 2'($urandom_range(0, 3));
            end else if (mode == 1) begin
                ce[k] = k == 0 ? 1'((cyc % 2) == 0) : 1'($urandom_range(0, 1));
                hsc[k] = 2'($urandom_range(0, 3));
                vsc[k] = 2'($urandom_range(0, 3));
            end else begin
                ce[k] = 1'($urandom_range(0, 3) != 0);
                hsc[k] = 2'($urandom_range(0, 3));
                vsc[k] = 2'($urandom_range(0, 3));
            end
        end
        started = 1;
        for (int k = 0; k < 3; k++) model(k, !reset_n, pulse);
        if (pulse) begin
            #2 reset_n = 1'b0;
            #1 for (int k = 0; k < 3; k++) check_inst(k, rst_exp(k));
            #1 reset_n = 1'b1;
        end
        cyc++;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (started) begin
                for (int k = 0; k < 3; k++) begin
                    if (q.size() == 0) begin
                        miscompares++;
                        $display("FAIL scoreboard inst%0d t=%0t got empty queue expected entry", k, $time);
                    end else begin
                        check_inst(k, q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            ce[k] = 1'b0; hsc[k] = 2'd0; vsc[k] = 2'd0;
        end
        repeat (3) step(0, 0, 0);
        step(1, 0, 0);
        repeat (2000) step(0, 0, 0);
        repeat (4000) step(0, 0, 1);
        step(0, 1, 2);
        repeat (6000) step(0, 0, 2);
        step(0, 1, 0);
        repeat (2000) step(0, 0, 0);
        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised successor of the fixed-mode 640x480 hvsync generator.
- Produces sync, data-enable, raster position, frame-buffer address and frame/line strobes for any CEA/VESA-style timing.
- Pixel rate is set by a clock enable, so one system clock can drive several resolutions.
- Adds programmable sync polarity, a configurable output pipeline delay to match frame-buffer read latency, and run-time pixel/line replication (x1/x2/x4) with a matching address generator.
- Sits between the frame-buffer read port and the DAC/pin drivers.

Parameters:
- H_DISPLAY, 640, active pixels per line.
- H_FRONT, 16, horizontal front porch (pixels).
- H_SYNC, 96, horizontal sync width (pixels).
- H_BACK, 48, horizontal back porch (pixels).
- V_DISPLAY, 480, active lines per frame.
- V_FRONT, 10, vertical front porch (lines).
- V_SYNC, 2, vertical sync width (lines).
- V_BACK, 33, vertical back porch (lines).
- H_SYNC_POL, 0, active level of hsync (0 = active-low).
- V_SYNC_POL, 0, active level of vsync.
- PIPE_DELAY, 2, pixel ticks by which hsync/vsync/display_on lag hpos/vpos/display_addr; legal range 1..8.
- CNT_W, 11, width of hpos/vpos.
- ADDR_W, 19, width of display_addr.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- pix_ce  input  1  pixel tick; all state except the strobes advances only when this is 1.
- h_scale  input  2  horizontal replication: 0 = x1, 1 = x2, 2 = x4, 3 treated as 2.
- v_scale  input  2  vertical replication, same encoding.
- hpos  output  CNT_W  raw horizontal counter.
- vpos  output  CNT_W  raw vertical counter.
- display_addr  output  ADDR_W  frame-buffer word address for the current (hpos, vpos).
- hsync  output  1  delayed horizontal sync at the H_SYNC_POL level.
- vsync  output  1  delayed vertical sync at the V_SYNC_POL level.
- display_on  output  1  delayed data enable.
- frame_start  output  1  one-clk strobe.
- line_start  output  1  one-clk strobe.

Behaviour:
- Derived totals: H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK (800 by default); V_TOTAL is formed the same way (525).
- Line order is display, front porch, sync, back porch. Frames follow the same order in lines.
- Reset (async assert, release sampled on clk):
  - hpos = H_TOTAL-1, vpos = V_TOTAL-1.
  - display_addr = 0, display_on = 0, strobes = 0.
  - hsync = ~H_SYNC_POL, vsync = ~V_SYNC_POL.
  - Delay pipeline cleared to the inactive values.
  - Latched scales = 0.
- Counters, on a clk edge with pix_ce = 1:
  - If hpos == H_TOTAL-1: hpos goes to 0, and vpos goes to vpos+1, or to 0 when vpos == V_TOTAL-1.
  - Otherwise hpos goes to hpos+1.
  - With the reset values above, the first tick after reset yields (0,0).
- Raw signals, decoded from hpos/vpos:
  - de_raw = hpos < H_DISPLAY && vpos < V_DISPLAY.
  - hs_raw is true for H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC.
  - vs_raw uses the same window on vpos with the V_ parameters.
- Delay pipeline:
  - de_raw/hs_raw/vs_raw pass through a PIPE_DELAY-stage shift register that shifts only on pix_ce.
  - Outputs are registered: hsync = hs_delayed ? H_SYNC_POL : ~H_SYNC_POL; vsync likewise.
  - With a constant pix_ce = 1, display_on rises exactly PIPE_DELAY clks after hpos becomes 0 on an active line.
- Scale latching: h_scale/v_scale are captured into internal hs/vs registers only on the tick that moves the counters to (0,0). Changes mid-frame have no effect until the next frame.
- Address generation:
  - While de_raw = 1: display_addr = (vpos >> vs) * (H_DISPLAY >> hs) + (hpos >> hs).
  - Implement incrementally with no multiplier: keep a line-base register and sub-pixel/sub-line counters. On replicated lines, rewind to the line base.
  - display_addr is registered in the same clk edge as hpos/vpos, so it always matches them.
  - Outside the active area it holds its last value, and is 0 at (0,0).
  - Arithmetic wraps modulo 2^ADDR_W; no saturation.
- Strobes:
  - frame_start = 1 for exactly the one clk following the tick that moved the counters to (0,0).
  - line_start = 1 for the one clk following any tick that moved hpos to 0.
  - Both strobes are 0 on every other clk, independent of how long pix_ce stays low afterwards.
- pix_ce = 0: all counters, the address, the pipeline and the sync/de outputs hold their values.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronously), regardless of clk or pix_ce.

Test Plan:
1. Defaults, pix_ce = 1, reset released:
   - First tick gives hpos = 0, vpos = 0, frame_start = 1 for one clk.
   - hsync low for exactly 96 clks, starting 656+2 clks after hpos = 0.
   - Line period is 800 clks; frame period is 420000 clks.
2. pix_ce toggling 1,0,1,0:
   - Line period is 1600 clks.
   - line_start is still a single-clk pulse per line.
   - Outputs hold on the ce = 0 cycles.
3. h_scale = 1, v_scale = 1 latched at frame start; check display_addr at each (hpos, vpos):
   - (0,0) = 0, (1,0) = 0, (2,0) = 1, (639,0) = 319.
   - (0,1) = 0, (0,2) = 320, (639,479) = 76799.
4. h_scale changed from 0 to 2 at vpos = 100:
   - Addresses keep x1 mapping until the next (0,0).
   - Next frame: (4,0) = 1, (0,1) = 160.
5. H_SYNC_POL = 1, V_SYNC_POL = 1, PIPE_DELAY = 1:
   - hsync/vsync are 0 at reset and 1 during sync.
   - display_on rises 1 clk after hpos = 0 with vpos = 0.
6. reset_n pulsed low at hpos = 300, vpos = 200 (not aligned to clk):
   - Outputs go to reset values without waiting for a clk edge.
   - After release, the first tick yields (0,0) and frame_start = 1.
